// File: rtl/meas_pkg.sv
// Shared types and constants for the measurement sequencer.
package meas_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET_TGT,
    S_SETTLE,
    S_MEASURE,
    S_REPORT,
    S_TX_WAIT
  } state_t;

  localparam logic [31:0] TIMEOUT_WORD = 32'hFFFF_FFFF;

  // A zero-length interval would never expire on a down-counter, so clamp to one cycle.
  function automatic logic [31:0] at_least_one(input logic [31:0] v);
    return (v == '0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/meas_seq_cyc_timer.sv
// Loadable 32-bit down-counter; o_done marks the last cycle of a loaded interval.
module cyc_timer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  output logic        o_done
);

  logic [31:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 32'd1;
    end
  end

  // Loading N gives N cycles in the new state; the Nth one sees count==1.
  assign o_done = (r_count == 32'd1);

endmodule

// File: rtl/meas_seq.sv
// Target reset / settle / response-time measurement sequencer with result reporting.
module meas_seq #(
  parameter int unsigned RST_CYCLES     = 100000,
  parameter int unsigned SETTLE_CYCLES  = 1000000,
  parameter int unsigned TIMEOUT_CYCLES = 120000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rst_req,
  input  logic        send_done,
  input  logic        resp_edge,
  input  logic [31:0] ticks,
  input  logic        tx_busy,
  output logic        cnt_clr,
  output logic        target_rst,
  output logic        tx_start,
  output logic [31:0] tx_data,
  output logic        ready,
  output logic        timeout
);
  import meas_pkg::*;

  localparam logic [31:0] LD_RST    = at_least_one(32'(RST_CYCLES));
  localparam logic [31:0] LD_SETTLE = at_least_one(32'(SETTLE_CYCLES));
  localparam logic [31:0] LD_MEAS   = at_least_one(32'(TIMEOUT_CYCLES));

  state_t      r_state;
  state_t      w_next;
  logic        r_pending;
  logic        r_seen_busy;
  logic        r_cnt_clr;
  logic [31:0] r_tx_data;
  logic        r_timeout;

  logic        w_load;
  logic [31:0] w_load_val;
  logic        w_done;
  logic        w_clr_pulse;
  logic        w_latch_resp;
  logic        w_latch_to;

  cyc_timer u_timer (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_load_val   = LD_RST;
    w_clr_pulse  = 1'b0;
    w_latch_resp = 1'b0;
    w_latch_to   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rst_req || r_pending) begin
          w_next = S_RESET_TGT;
          w_load = 1'b1;
        end else if (send_done) begin
          w_next      = S_MEASURE;
          w_load      = 1'b1;
          w_load_val  = LD_MEAS;
          w_clr_pulse = 1'b1;
        end
      end
      S_RESET_TGT: begin
        if (rst_req) begin
          w_load = 1'b1;
        end else if (w_done) begin
          w_next     = S_SETTLE;
          w_load     = 1'b1;
          w_load_val = LD_SETTLE;
        end
      end
      S_SETTLE: begin
        if (rst_req) begin
          w_next = S_RESET_TGT;
          w_load = 1'b1;
        end else if (w_done) begin
          w_next = S_IDLE;
        end
      end
      S_MEASURE: begin
        // Abort beats a response, and a response beats expiry in the same cycle.
        if (rst_req) begin
          w_next = S_RESET_TGT;
          w_load = 1'b1;
        end else if (resp_edge) begin
          w_next       = S_REPORT;
          w_latch_resp = 1'b1;
        end else if (w_done) begin
          w_next     = S_REPORT;
          w_latch_to = 1'b1;
        end
      end
      S_REPORT: begin
        if (!tx_busy) w_next = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (r_seen_busy && !tx_busy) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pending   <= 1'b0;
      r_seen_busy <= 1'b0;
      r_cnt_clr   <= 1'b0;
      r_tx_data   <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt_clr <= w_clr_pulse;
      if (w_clr_pulse) begin
        r_timeout <= 1'b0;
      end else if (w_latch_to) begin
        r_timeout <= 1'b1;
      end
      if (w_latch_resp) begin
        r_tx_data <= ticks;
      end else if (w_latch_to) begin
        r_tx_data <= TIMEOUT_WORD;
      end
      // IDLE always consumes the pending flag by heading into RESET_TGT.
      if (r_state == S_IDLE) begin
        r_pending <= 1'b0;
      end else if (rst_req && (r_state == S_REPORT || r_state == S_TX_WAIT)) begin
        r_pending <= 1'b1;
      end
      r_seen_busy <= (r_state == S_TX_WAIT) && (r_seen_busy || tx_busy);
    end
  end

  assign cnt_clr    = r_cnt_clr;
  assign target_rst = (r_state == S_RESET_TGT);
  assign tx_start   = (r_state == S_REPORT) && !tx_busy;
  assign tx_data    = r_tx_data;
  assign ready      = (r_state == S_IDLE);
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_meas_seq.sv
// Bench for meas_seq: directed scenarios plus random traffic against a phase/elapsed-time model.
module tb_meas_seq;

  localparam int unsigned RC = 4;
  localparam int unsigned SC = 8;
  localparam int unsigned TC = 50;

  logic        clk = 1'b0;
  logic        rst, rst_req, send_done, resp_edge, tx_busy;
  logic [31:0] ticks;
  logic        cnt_clr, target_rst, tx_start, ready, timeout;
  logic [31:0] tx_data;
  logic        z_cnt_clr, z_target_rst, z_tx_start, z_ready, z_timeout;
  logic [31:0] z_tx_data;

  always #5 clk = ~clk;

  meas_seq #(.RST_CYCLES(RC), .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TC)) u_dut (
    .clk(clk), .rst(rst), .rst_req(rst_req), .send_done(send_done), .resp_edge(resp_edge),
    .ticks(ticks), .tx_busy(tx_busy), .cnt_clr(cnt_clr), .target_rst(target_rst),
    .tx_start(tx_start), .tx_data(tx_data), .ready(ready), .timeout(timeout)
  );

  meas_seq #(.RST_CYCLES(0), .SETTLE_CYCLES(0), .TIMEOUT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .rst_req(rst_req), .send_done(send_done), .resp_edge(resp_edge),
    .ticks(ticks), .tx_busy(tx_busy), .cnt_clr(z_cnt_clr), .target_rst(z_target_rst),
    .tx_start(z_tx_start), .tx_data(z_tx_data), .ready(z_ready), .timeout(z_timeout)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which phase we are in and how many cycles it has lasted so far.
  typedef enum {P_IDLE, P_RST, P_SETTLE, P_MEAS, P_REP, P_WAIT} phase_t;
  phase_t      ph = P_IDLE;
  int unsigned el = 0;
  bit          pend = 0, seen = 0, m_clr = 0, m_to = 0, model_on = 0;
  logic [31:0] m_data = '0;

  function automatic int unsigned atleast1(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  always @(posedge clk) begin : model
    phase_t nph;
    bit     restart;
    nph     = ph;
    restart = 0;
    if (rst) begin
      ph = P_IDLE; el = 0; pend = 0; seen = 0; m_clr = 0; m_to = 0; m_data = '0;
      model_on = 1;
    end else begin
      m_clr = 0;
      case (ph)
        P_IDLE:
          if (rst_req || pend) begin nph = P_RST; pend = 0; end
          else if (send_done) begin nph = P_MEAS; m_clr = 1; m_to = 0; end
        P_RST:
          if (rst_req) restart = 1;
          else if (el + 1 >= atleast1(RC)) nph = P_SETTLE;
        P_SETTLE:
          if (rst_req) nph = P_RST;
          else if (el + 1 >= atleast1(SC)) nph = P_IDLE;
        P_MEAS:
          if (rst_req) nph = P_RST;
          else if (resp_edge) begin m_data = ticks; nph = P_REP; end
          else if (el + 1 >= atleast1(TC)) begin m_data = 32'hFFFF_FFFF; m_to = 1; nph = P_REP; end
        P_REP: begin
          if (rst_req) pend = 1;
          if (!tx_busy) begin nph = P_WAIT; seen = 0; end
        end
        P_WAIT: begin
          if (rst_req) pend = 1;
          if (seen && !tx_busy) nph = P_IDLE;
          else if (tx_busy) seen = 1;
        end
        default: nph = P_IDLE;
      endcase
      if (restart || nph != ph) el = 0;
      else el = el + 1;
      ph = nph;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("ready",      32'(ready),      32'(ph == P_IDLE));
      check("target_rst", 32'(target_rst), 32'(ph == P_RST));
      check("cnt_clr",    32'(cnt_clr),    32'(m_clr));
      check("tx_start",   32'(tx_start),   32'(ph == P_REP && !tx_busy));
      check("tx_data",    tx_data,         m_data);
      check("timeout",    32'(timeout),    32'(m_to));
    end
  end

  int n_trst, n_start, n_clr, n_ready, n_ztrst;

  task automatic clr_counts();
    n_trst = 0; n_start = 0; n_clr = 0; n_ready = 0; n_ztrst = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    rst = 1'b0; rst_req = 1'b0; send_done = 1'b0; resp_edge = 1'b0;
    ticks = $urandom;
  endtask

  task automatic obs();
    @(negedge clk);
    n_trst  += int'(target_rst);
    n_start += int'(tx_start);
    n_clr   += int'(cnt_clr);
    n_ready += int'(ready);
    n_ztrst += int'(z_target_rst);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  initial begin
    int first_rdy, zfirst;
    rst = 1'b1; rst_req = 1'b0; send_done = 1'b0; resp_edge = 1'b0; tx_busy = 1'b0; ticks = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    obs();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_trst", 32'(target_rst), 32'd0);
    check("rst_data", tx_data, 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);

    // Target reset: 4 cycles driven, 8 settle, IDLE on the 13th cycle after the request.
    cyc(); rst_req = 1'b1; obs();
    clr_counts(); first_rdy = 0; zfirst = 0;
    for (int k = 1; k <= 14; k++) begin
      cyc(); obs();
      if (ready && first_rdy == 0) first_rdy = k;
      if (z_ready && zfirst == 0) zfirst = k;
    end
    check("d1_trst_cycles", 32'(n_trst), 32'd4);
    check("d1_ready_back", 32'(first_rdy), 32'd13);
    check("zero_trst_cycles", 32'(n_ztrst), 32'd1);
    check("zero_ready_back", 32'(zfirst), 32'd3);

    // Response measured.
    cyc(); send_done = 1'b1; obs();
    cyc(); obs();
    check("d2_cnt_clr_n1", 32'(cnt_clr), 32'd1);
    cyc(); obs();
    check("d2_cnt_clr_n2", 32'(cnt_clr), 32'd0);
    cyc(); obs();
    cyc(); obs();
    cyc(); resp_edge = 1'b1; ticks = 32'h1234; obs();
    cyc(); obs();
    check("d2_tx_start", 32'(tx_start), 32'd1);
    check("d2_tx_data", tx_data, 32'h0000_1234);
    check("d2_timeout", 32'(timeout), 32'd0);
    cyc(); tx_busy = 1'b1; obs();
    cyc(); obs();
    cyc(); tx_busy = 1'b0; obs();
    check("d2_not_ready_yet", 32'(ready), 32'd0);
    cyc(); obs();
    check("d2_ready", 32'(ready), 32'd1);

    // Timeout, with the transmitter busy for the first 20 cycles of REPORT.
    cyc(); send_done = 1'b1; obs();
    clr_counts();
    for (int k = 1; k <= 76; k++) begin
      cyc();
      tx_busy = (k <= 70) || (k >= 72 && k <= 74);
      obs();
      if (k == 50) begin
        check("d3_data_before", tx_data, 32'h0000_1234);
        check("d3_to_before", 32'(timeout), 32'd0);
      end
      if (k == 51) begin
        check("d3_data_to", tx_data, 32'hFFFF_FFFF);
        check("d3_timeout", 32'(timeout), 32'd1);
      end
      if (k == 70) check("d3_no_start_busy", 32'(n_start), 32'd0);
      if (k == 71) check("d3_start_after_busy", 32'(tx_start), 32'd1);
      if (k == 76) begin
        check("d3_ready", 32'(ready), 32'd1);
        check("d3_one_start", 32'(n_start), 32'd1);
      end
    end

    // Abort mid-measure; a send_done during SETTLE must not be queued.
    cyc(); send_done = 1'b1; obs();
    clr_counts();
    for (int k = 1; k <= 30; k++) begin
      cyc();
      rst_req   = (k == 10);
      send_done = (k == 18);
      obs();
    end
    check("d4_trst_cycles", 32'(n_trst), 32'd4);
    check("d4_no_start", 32'(n_start), 32'd0);
    check("d4_clr_once", 32'(n_clr), 32'd1);
    check("d4_ready_cycles", 32'(n_ready), 32'd8);
    check("d4_data_kept", tx_data, 32'hFFFF_FFFF);

    // Reset requested during TX_WAIT: report completes, then the reset runs.
    cyc(); send_done = 1'b1; obs();
    clr_counts();
    for (int k = 1; k <= 22; k++) begin
      cyc();
      resp_edge = (k == 3);
      if (k == 3) ticks = 32'h0000_A5A5;
      tx_busy = (k == 5 || k == 6);
      rst_req = (k == 5);
      obs();
      if (k == 4) check("d5_tx_start", 32'(tx_start), 32'd1);
      if (k == 8) check("d5_idle_between", 32'(ready), 32'd1);
      if (k == 9) check("d5_pending_reset", 32'(target_rst), 32'd1);
    end
    check("d5_one_start", 32'(n_start), 32'd1);
    check("d5_trst_cycles", 32'(n_trst), 32'd4);
    check("d5_data", tx_data, 32'h0000_A5A5);

    // Synchronous reset in the middle of a target reset.
    cyc(); rst_req = 1'b1; obs();
    cyc(); obs();
    check("d6_in_reset", 32'(target_rst), 32'd1);
    cyc(); rst = 1'b1; obs();
    cyc(); obs();
    check("d6_trst_dropped", 32'(target_rst), 32'd0);
    check("d6_ready", 32'(ready), 32'd1);
    check("d6_data", tx_data, 32'd0);
    check("d6_timeout", 32'(timeout), 32'd0);
    check("d6_cnt_clr", 32'(cnt_clr), 32'd0);
    check("d6_tx_start", 32'(tx_start), 32'd0);

    for (int i = 0; i < 4000; i++) begin
      cyc();
      rst       = ($urandom_range(0, 799) == 0);
      rst_req   = ($urandom_range(0, 149) == 0);
      send_done = ($urandom_range(0, 7) == 0);
      resp_edge = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) tx_busy = ~tx_busy;
      obs();
    end

    cyc(); obs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
